// File: rtl/hack_screen_scanout.sv
// Hack screen scanout: reads the 512x256 screen RAM and emits a VGA-style pixel stream.
// Define SCANOUT_LINE_DOUBLE_EN to show each screen row on two consecutive lines.
module hack_screen_scanout #(
    parameter int unsigned H_ACTIVE = 512,
    parameter int unsigned H_FP     = 64,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 128,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [12:0] rd_addr,
    output logic        rd_en,
    input  logic [15:0] rd_data,
    output logic        pixel,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);
`ifdef SCANOUT_LINE_DOUBLE_EN
    localparam int unsigned V_ACT = 512;
`else
    localparam int unsigned V_ACT = 256;
`endif
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_PREFETCH = HW'(H_TOTAL - 2);
    localparam logic [HW-1:0] H_VIS_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_END  = VW'(V_ACT);
    localparam logic [VW-1:0] VS_START   = VW'(V_ACT + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACT + V_FP + V_SYNC);

    logic [HW-1:0] h_cnt;
    logic [HW-1:0] fetch_h;
    logic [VW-1:0] v_cnt;
    logic [VW-1:0] v_next;
    logic [VW-1:0] fetch_v;
    logic [7:0]    fetch_row;
    logic          visible;
    logic          fetch;
    logic          in_hsync;
    logic          in_vsync;
    logic          rd_valid;
    logic [15:0]   shift;

    always_comb begin
        v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        // Fetch position runs two pixels ahead so a word lands exactly on its first column.
        if (h_cnt >= H_PREFETCH) begin
            fetch_h = h_cnt - H_PREFETCH;
            fetch_v = v_next;
        end else begin
            fetch_h = h_cnt + HW'(2);
            fetch_v = v_cnt;
        end
`ifdef SCANOUT_LINE_DOUBLE_EN
        fetch_row = fetch_v[8:1];
`else
        fetch_row = fetch_v[7:0];
`endif
        visible  = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
        fetch    = enable && (fetch_h < H_VIS_END) && (fetch_h[3:0] == 4'd0)
                   && (fetch_v < V_VIS_END);
        in_hsync = (h_cnt >= HS_START) && (h_cnt < HS_END);
        in_vsync = (v_cnt >= VS_START) && (v_cnt < VS_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            rd_valid    <= 1'b0;
            shift       <= '0;
            pixel       <= 1'b0;
            de          <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= v_next;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
            rd_en <= fetch;
            if (fetch) begin
                rd_addr <= {fetch_row, fetch_h[8:4]};
            end
            rd_valid    <= rd_en;
            de          <= visible;
            hsync       <= ~in_hsync;
            vsync       <= ~in_vsync;
            frame_start <= visible && (h_cnt == '0) && (v_cnt == '0);
            // Clearing the shifter while disabled keeps stale bits off screen until a fresh word.
            if (!enable) begin
                pixel <= 1'b0;
                shift <= '0;
            end else if (rd_valid) begin
                pixel <= visible & rd_data[0];
                shift <= {1'b0, rd_data[15:1]};
            end else begin
                pixel <= visible & shift[0];
                shift <= {1'b0, shift[15:1]};
            end
        end
    end

endmodule

// File: tb/tb_hack_screen_scanout.sv
// Bench for hack_screen_scanout: random screen contents and enable pattern, every output
// compared each cycle against a frame-position reference model.
module tb_hack_screen_scanout;
    localparam int HFP   = 8;
    localparam int HSYNC = 16;
    localparam int HBP   = 24;
    localparam int HT    = 512 + HFP + HSYNC + HBP;
    localparam int VT    = 256 + 1 + 2 + 10;
    localparam int FRAME = HT * VT;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [12:0] rd_addr;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        pixel;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic        frame_start;

    hack_screen_scanout #(
        .H_ACTIVE(512),
        .H_FP    (HFP),
        .H_SYNC  (HSYNC),
        .H_BP    (HBP),
        .V_FP    (1),
        .V_SYNC  (2),
        .V_BP    (10)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .pixel      (pixel),
        .de         (de),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_start(frame_start)
    );

    bit [15:0]   mem     [0:8191];
    bit          en_hist [0:65535];
    int          n;
    int          checks;
    int          errors;
    logic [12:0] last_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous screen RAM: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    // Pixel at output n shows bit b of the word for its column, provided that word was
    // fetched while enabled and enable stayed high from the word's first column until now.
    function automatic bit exp_pixel(input int cyc);
        int pos;
        int x;
        int y;
        int b;
        int nf;
        pos = (cyc - 1) % FRAME;
        x   = pos % HT;
        y   = pos / HT;
        b   = x % 16;
        nf  = cyc - b - 2;
        if (!(x < 512 && y < 256)) return 1'b0;
        if (nf < 1) return 1'b0;
        if (!en_hist[nf]) return 1'b0;
        for (int k = cyc - b; k <= cyc; k++) begin
            if (!en_hist[k]) return 1'b0;
        end
        return mem[y * 32 + x / 16][b];
    endfunction

    task automatic step();
        int pos;
        int x;
        int y;
        int q;
        int qx;
        int qy;
        bit de_e;
        bit hs_e;
        bit vs_e;
        bit rd_e;
        @(posedge clk);
        n++;
        en_hist[n] = enable;
        #1;
        pos  = (n - 1) % FRAME;
        x    = pos % HT;
        y    = pos / HT;
        q    = (pos + 2) % FRAME;
        qx   = q % HT;
        qy   = q / HT;
        de_e = (x < 512) && (y < 256);
        hs_e = !(x >= 512 + HFP && x < 512 + HFP + HSYNC);
        vs_e = !(y >= 257 && y < 259);
        rd_e = en_hist[n] && (qx < 512) && (qx % 16 == 0) && (qy < 256);
        if (rd_e) last_addr = 13'(qy * 32 + qx / 16);
        chk("de", 16'(de), 16'(de_e));
        chk("hsync", 16'(hsync), 16'(hs_e));
        chk("vsync", 16'(vsync), 16'(vs_e));
        chk("frame_start", 16'(frame_start), 16'(pos == 0));
        chk("rd_en", 16'(rd_en), 16'(rd_e));
        chk("rd_addr", 16'(rd_addr), 16'(last_addr));
        chk("pixel", 16'(pixel), 16'(exp_pixel(n)));
    endtask

    initial begin
        int line;
        checks    = 0;
        errors    = 0;
        n         = 0;
        last_addr = '0;
        rst_n     = 1'b0;
        enable    = 1'b1;
        for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_de", 16'(de), 16'd0);
        chk("rst_hsync", 16'(hsync), 16'd1);
        chk("rst_vsync", 16'(vsync), 16'd1);
        chk("rst_rd_en", 16'(rd_en), 16'd0);
        chk("rst_rd_addr", 16'(rd_addr), 16'd0);
        chk("rst_pixel", 16'(pixel), 16'd0);
        chk("rst_frame_start", 16'(frame_start), 16'd0);

        @(negedge clk);
        rst_n = 1'b1;
        // Lines 5..19 toggle enable at random, line 22 is fully disabled.
        while (n < 30 * HT + 301) begin
            step();
            line = (n % FRAME) / HT;
            if (line >= 5 && line <= 19) begin
                if ($urandom_range(0, 99) < 3) enable = ~enable;
            end else begin
                enable = (line != 22);
            end
        end

        // Mid-line reset: outputs must drop to reset values without waiting for a clock.
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_hsync", 16'(hsync), 16'd1);
        chk("mid_rst_vsync", 16'(vsync), 16'd1);
        chk("mid_rst_de", 16'(de), 16'd0);
        chk("mid_rst_rd_en", 16'(rd_en), 16'd0);
        chk("mid_rst_rd_addr", 16'(rd_addr), 16'd0);
        chk("mid_rst_pixel", 16'(pixel), 16'd0);
        chk("mid_rst_frame_start", 16'(frame_start), 16'd0);
        repeat (2) @(negedge clk);
        enable    = 1'b1;
        n         = 0;
        last_addr = '0;
        rst_n     = 1'b1;
        while (n < 25 * HT) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
